z_event_monitor: RTL
====================

Z_EVENT_MONITOR -- requirements
Module: z_event_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the event counter, run-length counter and threshold.
REQ-002 Parameter GAP_MIN, default 2, legal range 1..15: consecutive low cycles of z_in needed to close an event.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 z_in  input  1  detect output of the upstream "more than one 1s" FSM; level, synchronous to clk.
REQ-006 clr  input  1  synchronous clear of statistics, active-high.
REQ-007 thresh  input  CNT_W  alarm threshold; value 0 disables the alarm.
REQ-008 evt_pulse  output  1  one-cycle pulse per new event.
REQ-009 evt_cnt  output  CNT_W  number of events since the last reset or clear, saturating.
REQ-010 in_run  output  1  high while the FSM is in RUN or GAP.
REQ-011 alarm  output  1  sticky flag: evt_cnt has reached thresh.
REQ-012 max_run  output  CNT_W  longest event run length, in z_in-high cycles (see Configuration).

Function
REQ-013 FSM states: IDLE, RUN, GAP. All outputs are registered.
REQ-014 IDLE with z_in=1 -> RUN; next cycle evt_pulse=1, evt_cnt+1, run_len=1 (one-cycle latency from sampled z_in).
REQ-015 IDLE with z_in=0 -> stay in IDLE.
REQ-016 RUN with z_in=1 -> stay in RUN; run_len+1, saturating at 2^CNT_W-1.
REQ-017 RUN with z_in=0 -> GAP, gap_cnt=1.
REQ-018 GAP with z_in=0 and gap_cnt<GAP_MIN -> gap_cnt+1.
REQ-019 GAP with gap_cnt reaching GAP_MIN -> IDLE; event closed; max_run updated (REQ-030).
REQ-020 GAP with z_in=1 before close -> RUN; no new event, no evt_pulse; run_len resumes incrementing (gap merged).
REQ-021 evt_cnt saturates at 2^CNT_W-1 and never wraps; evt_pulse still fires at saturation.
REQ-022 alarm sets on the cycle evt_cnt becomes >= thresh with thresh!=0, and stays set until clr or rst.
REQ-023 A change to thresh takes effect on the next evt_cnt update only; alarm never self-clears.
REQ-024 clr=1 -> next cycle evt_cnt=0, alarm=0, max_run=0. FSM state, run_len and gap_cnt are unaffected.
REQ-025 clr coincident with a new event: clr has priority, so evt_cnt=0; evt_pulse still asserts.
REQ-026 in_run=1 exactly when state is RUN or GAP.

Reset
REQ-027 rst=1 at a clock edge -> state=IDLE, evt_pulse=0, evt_cnt=0, in_run=0, alarm=0, max_run=0, run_len=0, gap_cnt=0.
REQ-028 rst has priority over clr and z_in; reset mid-run discards the open event without updating max_run.
REQ-029 The first event can be recognised on the first edge after rst deasserts.

Configuration
REQ-030 Macro Z_MON_RUN_LEN_EN defined: run_len is tracked; on event close, max_run = max(max_run, run_len).
REQ-031 Macro Z_MON_RUN_LEN_EN undefined: no run_len or max_run storage exists and max_run is tied to 0. All other behaviour is identical.

Verification (CNT_W=8, GAP_MIN=2, macro defined unless noted)
REQ-032 rst high 2 cycles with z_in toggling -> all outputs 0, state IDLE throughout.
REQ-033 z_in high 3 cycles, then low 2 -> one evt_pulse 1 cycle after the rise; evt_cnt=1; in_run high 5 cycles; max_run=3.
REQ-034 z_in pattern 1,1,0,1,1,0,0 -> single event: evt_cnt=1, max_run=4, no second evt_pulse.
REQ-035 thresh=3, three separated events, then clr -> alarm rises with evt_cnt=3 and stays through a 4th event (evt_cnt=4); after clr, evt_cnt=0 and alarm=0.
REQ-036 CNT_W=4, 17 separated events -> evt_cnt holds at 15 with 17 evt_pulses; clr together with the 18th event -> evt_cnt=0, evt_pulse=1.
REQ-037 Macro undefined, z_in high 6 cycles then low 2 -> max_run=0 while evt_cnt=1; rst asserted mid-run -> IDLE next cycle.

Source files
------------

// File: rtl/z_event_monitor.sv
// -----------------------------------------------------------------------------
// z_event_monitor
//
// Watches the level-type detect output of an upstream "more than one 1s" FSM
// and turns it into discrete events. A run of z_in-high cycles opens an event.
// Short low gaps (fewer than GAP_MIN cycles) are merged into the same event.
// The block keeps a saturating event count and a sticky threshold alarm.
// When run-length tracking is compiled in, it also keeps the longest run
// length seen.
//
// Build option:
//   Z_MON_RUN_LEN_EN  when defined, run_len is tracked and max_run reports
//                     the longest closed event. When undefined, no run-length
//                     storage exists and max_run is tied to zero.
//
// Parameters:
//   CNT_W    width of the event counter, run-length counter and threshold
//   GAP_MIN  consecutive low cycles of z_in that close an event (1..15)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous reset, active-high, highest priority
//   z_in       upstream detect level
//   clr        synchronous clear of evt_cnt / alarm / max_run
//   thresh     alarm threshold, 0 disables the alarm
//   evt_pulse  one-cycle pulse per new event
//   evt_cnt    saturating count of events since reset/clear
//   in_run     high while an event is open (RUN or GAP)
//   alarm      sticky: evt_cnt has reached thresh
//   max_run    longest event run length in z_in-high cycles
// -----------------------------------------------------------------------------
module z_event_monitor #(
    parameter int CNT_W   = 8,
    parameter int GAP_MIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             in_run,
    output logic             alarm,
    output logic [CNT_W-1:0] max_run
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       GAP_LIMIT = 4'(GAP_MIN);

    state_t           state_q, state_d;
    logic [3:0]       gapCnt_q, gapCnt_d;
    logic             evtPulse_q, evtPulse_d;
    logic [CNT_W-1:0] evtCnt_q, evtCnt_d;
    logic             inRun_q, inRun_d;
    logic             alarm_q, alarm_d;

    // State register and registered outputs; rst beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gapCnt_q   <= '0;
            evtPulse_q <= 1'b0;
            evtCnt_q   <= '0;
            inRun_q    <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gapCnt_q   <= gapCnt_d;
            evtPulse_q <= evtPulse_d;
            evtCnt_q   <= evtCnt_d;
            inRun_q    <= inRun_d;
            alarm_q    <= alarm_d;
        end
    end

    // Next-state and statistics logic.
    // The close check in GAP comes first: once GAP_MIN low cycles have been
    // counted, the event ends on this edge whatever z_in is doing.
    // The alarm is only re-evaluated when the counter moves. A threshold
    // change therefore waits for the next event. clr wipes the statistics
    // last, so it wins over a coincident increment. The pulse is not
    // affected by clr.
    always_comb begin
        state_d    = state_q;
        gapCnt_d   = gapCnt_q;
        evtPulse_d = 1'b0;
        evtCnt_d   = evtCnt_q;
        alarm_d    = alarm_q;

        case (state_q)
            IDLE: begin
                if (z_in) begin
                    state_d    = RUN;
                    evtPulse_d = 1'b1;
                    if (evtCnt_q != CNT_MAX) begin
                        evtCnt_d = evtCnt_q + 1'b1;
                    end
                    if ((thresh != '0) && (evtCnt_d >= thresh)) begin
                        alarm_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!z_in) begin
                    state_d  = GAP;
                    gapCnt_d = 4'd1;
                end
            end
            GAP: begin
                if (gapCnt_q >= GAP_LIMIT) begin
                    state_d = IDLE;
                end else if (z_in) begin
                    state_d = RUN;
                end else begin
                    gapCnt_d = gapCnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            evtCnt_d = '0;
            alarm_d  = 1'b0;
        end

        inRun_d = (state_d != IDLE);
    end

    assign evt_pulse = evtPulse_q;
    assign evt_cnt   = evtCnt_q;
    assign in_run    = inRun_q;
    assign alarm     = alarm_q;

`ifdef Z_MON_RUN_LEN_EN
    logic [CNT_W-1:0] runLen_q, runLen_d;
    logic [CNT_W-1:0] maxRun_q, maxRun_d;
    logic             runStart;
    logic             runStep;
    logic             runClose;

    // Decode the same FSM transitions that move run length.
    // A merge from GAP back to RUN counts as another high cycle.
    assign runStart = (state_q == IDLE) && z_in;
    assign runClose = (state_q == GAP) && (gapCnt_q >= GAP_LIMIT);
    assign runStep  = z_in && ((state_q == RUN) || ((state_q == GAP) && !runClose));

    // Run-length and maximum registers. A reset drops an open event
    // without folding it into max_run.
    always_ff @(posedge clk) begin
        if (rst) begin
            runLen_q <= '0;
            maxRun_q <= '0;
        end else begin
            runLen_q <= runLen_d;
            maxRun_q <= maxRun_d;
        end
    end

    // Saturating run counter. The maximum only updates on event close, and
    // clr clears it even on a closing edge.
    always_comb begin
        runLen_d = runLen_q;
        maxRun_d = maxRun_q;
        if (runStart) begin
            runLen_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (runStep && (runLen_q != CNT_MAX)) begin
            runLen_d = runLen_q + 1'b1;
        end
        if (runClose && (runLen_q > maxRun_q)) begin
            maxRun_d = runLen_q;
        end
        if (clr) begin
            maxRun_d = '0;
        end
    end

    assign max_run = maxRun_q;
`else
    assign max_run = '0;
`endif

endmodule
